lcd_write_controller: RTL and testbench

- Downstream consumer of the data-memory LCD port.
- Accepts a 10-bit LCD command word plus a start strobe from the memory-mapped LCD register.
- Performs HD44780-compatible 8-bit write timing with a power-on init sequence.
- Returns a one-cycle finish pulse to the processor, so software can poll for completion before issuing the next character or command.

---
 rtl/lcd_write_controller_if.sv | 29 ++
 rtl/lcd_write_controller.sv | 193 +++++++++++++++++++
 tb/tb_lcd_write_controller.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_controller_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_write_controller_if
// Brief    : Command/handshake and LCD pin bundle for lcd_write_controller.
//            The master side issues command words; the slave side is the
//            controller that drives the LCD pins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface lcd_write_controller_if;
   logic [9:0] lcd_data;   // [9]=RS, [8]=reserved, [7:0]=DB
   logic       start;
   logic       finish;
   logic       ready;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_db;

   modport master (
      output lcd_data, start,
      input  finish, ready, lcd_rs, lcd_rw, lcd_e, lcd_db
   );

   modport slave (
      input  lcd_data, start,
      output finish, ready, lcd_rs, lcd_rw, lcd_e, lcd_db
   );
endinterface
`default_nettype wire

// File: rtl/lcd_write_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_write_controller
// Brief    : HD44780-compatible 8-bit write sequencer. Runs the power-on init
//            sequence, then accepts one command/data word per start strobe
//            and returns a one-cycle finish pulse when the write has settled.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_write_controller #(
   parameter int SETUP_CYC     = 2,
   parameter int E_HIGH_CYC    = 12,
   parameter int HOLD_CYC      = 2,
   parameter int EXEC_CYC      = 2000,
   parameter int LONG_EXEC_CYC = 80000,
   parameter int INIT_WAIT_CYC = 750000,
   parameter int CNT_W         = 20
) (
   input  wire logic                   clk,
   input  wire logic                   rst,   // asynchronous, active low
   lcd_write_controller_if.slave       bus
);

   typedef enum logic [2:0] {
      S_INIT_WAIT = 3'd0,
      S_SETUP     = 3'd1,
      S_E_HIGH    = 3'd2,
      S_HOLD      = 3'd3,
      S_EXEC      = 3'd4,
      S_DONE      = 3'd5,
      S_IDLE      = 3'd6
   } state_t;

   // Counter reload values: a state lasting N cycles is entered with N-1.
   localparam logic [CNT_W-1:0] SETUP_LD     = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] E_HIGH_LD    = CNT_W'(E_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD      = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] EXEC_LD      = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_EXEC_LD = CNT_W'(LONG_EXEC_CYC - 1);
   // The counter comes out of reset at zero, so the first INIT_WAIT cycle
   // only arms it; the remaining INIT_WAIT_CYC-1 cycles are counted down.
   localparam logic [CNT_W-1:0] INIT_ARM_LD  = CNT_W'(INIT_WAIT_CYC - 2);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       init_idx_q, init_idx_d;
   logic             init_done_q, init_done_d;
   logic             armed_q, armed_d;
   logic             rs_q, rs_d;
   logic [7:0]       db_q, db_d;
   logic             e_q, e_d;
   logic             finish_q, finish_d;
   logic             ready_q, ready_d;

   logic             cnt_zero;
   logic             long_exec;
   logic             reserved_unused;

   // Bit 8 of the command word carries no meaning for this block.
   assign reserved_unused = bus.lcd_data[8];

   // Power-on init commands: function set, display on, clear, entry mode.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
   endfunction

   assign cnt_zero = (cnt_q == '0);
   // Clear display (0x01) and return home (0x02/0x03) need the long wait.
   assign long_exec = !rs_q && (db_q[7:2] == 6'd0) && (db_q[1:0] != 2'd0);

   // Next-state, counter and latched-bus logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_zero ? cnt_q : (cnt_q - CNT_ONE);
      init_idx_d  = init_idx_q;
      init_done_d = init_done_q;
      armed_d     = armed_q;
      rs_d        = rs_q;
      db_d        = db_q;

      case (state_q)
         S_INIT_WAIT: begin
            if ((armed_q && cnt_zero) || (!armed_q && (INIT_WAIT_CYC < 2))) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               rs_d    = 1'b0;
               db_d    = init_cmd(init_idx_q);
               armed_d = 1'b1;
            end else if (!armed_q) begin
               armed_d = 1'b1;
               cnt_d   = INIT_ARM_LD;
            end
         end
         S_SETUP: begin
            if (cnt_zero) begin
               state_d = S_E_HIGH;
               cnt_d   = E_HIGH_LD;
            end
         end
         S_E_HIGH: begin
            if (cnt_zero) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
            end
         end
         S_HOLD: begin
            if (cnt_zero) begin
               state_d = S_EXEC;
               cnt_d   = long_exec ? LONG_EXEC_LD : EXEC_LD;
            end
         end
         S_EXEC: begin
            if (cnt_zero) begin
               if (init_done_q) begin
                  state_d = S_DONE;
               end else if (init_idx_q == 2'd3) begin
                  state_d     = S_IDLE;
                  init_done_d = 1'b1;
               end else begin
                  state_d    = S_SETUP;
                  cnt_d      = SETUP_LD;
                  init_idx_d = init_idx_q + 2'd1;
                  rs_d       = 1'b0;
                  db_d       = init_cmd(init_idx_q + 2'd1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               rs_d    = bus.lcd_data[9];
               db_d    = bus.lcd_data[7:0];
            end
         end
         default: begin
            state_d = S_INIT_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      e_d      = (state_d == S_E_HIGH);
      finish_d = (state_d == S_DONE);
      ready_d  = (state_d == S_IDLE);
   end

   // State, counter and output registers; reset aborts any transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_INIT_WAIT;
         cnt_q       <= '0;
         init_idx_q  <= 2'd0;
         init_done_q <= 1'b0;
         armed_q     <= 1'b0;
         rs_q        <= 1'b0;
         db_q        <= 8'h00;
         e_q         <= 1'b0;
         finish_q    <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_idx_q  <= init_idx_d;
         init_done_q <= init_done_d;
         armed_q     <= armed_d;
         rs_q        <= rs_d;
         db_q        <= db_d;
         e_q         <= e_d;
         finish_q    <= finish_d;
         ready_q     <= ready_d;
      end
   end

   assign bus.lcd_rs = rs_q;
   assign bus.lcd_db = db_q;
   assign bus.lcd_e  = e_q;
   assign bus.lcd_rw = 1'b0;
   assign bus.finish = finish_q;
   assign bus.ready  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_controller.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_lcd_write_controller
// Brief    : Self-checking bench for lcd_write_controller with a timing
//            reference model derived from the write/init rules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lcd_write_controller;

   localparam int SETUP  = 2;
   localparam int E_HIGH = 4;
   localparam int HOLD   = 2;
   localparam int EXEC   = 10;
   localparam int LONG   = 50;
   localparam int INIT   = 100;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lcd_write_controller_if bus();

   lcd_write_controller #(
      .SETUP_CYC    (SETUP),
      .E_HIGH_CYC   (E_HIGH),
      .HOLD_CYC     (HOLD),
      .EXEC_CYC     (EXEC),
      .LONG_EXEC_CYC(LONG),
      .INIT_WAIT_CYC(INIT),
      .CNT_W        (20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observation record of the LCD pins and finish pulses.
   int         rise_cyc[$];
   logic [7:0] rise_db[$];
   logic       rise_rs[$];
   int         width_q[$];
   int         fin_cyc[$];
   int         ready_rise = -1;
   logic       e_prev     = 1'b0;
   logic       rdy_prev   = 1'b0;
   int         e_start    = 0;

   always @(negedge clk) begin
      if (!rst) begin
         e_prev   = 1'b0;
         rdy_prev = 1'b0;
      end else begin
         if (bus.lcd_e && !e_prev) begin
            rise_cyc.push_back(cyc);
            rise_db.push_back(bus.lcd_db);
            rise_rs.push_back(bus.lcd_rs);
            e_start = cyc;
         end
         if (!bus.lcd_e && e_prev) width_q.push_back(cyc - e_start);
         if (bus.finish) fin_cyc.push_back(cyc);
         if (bus.ready && !rdy_prev && ready_rise < 0) ready_rise = cyc;
         e_prev   = bus.lcd_e;
         rdy_prev = bus.ready;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference timing rules.
   function automatic int exec_len(input logic rs, input logic [7:0] db);
      return (!rs && db >= 8'h01 && db <= 8'h03) ? LONG : EXEC;
   endfunction

   function automatic int latency(input logic [9:0] data);
      return SETUP + E_HIGH + HOLD + exec_len(data[9], data[7:0]) + 1;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rise_cyc.delete();
      rise_db.delete();
      rise_rs.delete();
      width_q.delete();
      fin_cyc.delete();
      ready_rise = -1;
   endtask

   // Releases reset and checks the complete power-on sequence.
   task automatic run_init();
      logic [7:0] cmds [4];
      int rel;
      cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
      clear_mon();
      tick();
      rst = 1'b1;
      rel = cyc;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 40 || i == 120) begin
            bus.lcd_data = 10'h242;
            bus.start    = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      chk("init_e_count", rise_cyc.size(), 4);
      chk("init_width_count", width_q.size(), 4);
      chk("init_finish_count", fin_cyc.size(), 0);
      if (rise_cyc.size() == 4 && width_q.size() == 4) begin
         chk("init_first_wait", (rise_cyc[0] - rel >= INIT) && (rise_cyc[0] - rel <= INIT + 10), 1);
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("init_db%0d", k), rise_db[k], cmds[k]);
            chk($sformatf("init_rs%0d", k), rise_rs[k], 0);
            chk($sformatf("init_w%0d", k), width_q[k], E_HIGH);
         end
         for (int k = 0; k < 3; k++)
            chk($sformatf("init_gap%0d", k), rise_cyc[k+1] - rise_cyc[k],
                E_HIGH + HOLD + exec_len(1'b0, cmds[k]) + SETUP);
         chk("init_ready_rise", ready_rise, rise_cyc[3] + E_HIGH + HOLD + EXEC);
      end
      chk("init_ready_now", bus.ready, 1);
   endtask

   // One accepted write; optionally disturbs lcd_data and pulses start mid-flight.
   task automatic do_write(input logic [9:0] data, input bit disturb);
      int a, lat, d;
      lat = latency(data);
      d   = $urandom_range(1, lat - 3);
      chk("ready_before", bus.ready, 1);
      clear_mon();
      bus.lcd_data = data;
      bus.start    = 1'b1;
      tick();
      a = cyc;
      bus.start = 1'b0;
      chk("ready_after_accept", bus.ready, 0);
      while (cyc < a + lat) begin
         tick();
         if (disturb && cyc == a + d) begin
            bus.lcd_data = 10'h242;
            bus.start    = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      chk("wr_e_count", rise_cyc.size(), 1);
      chk("wr_fin_count", fin_cyc.size(), 1);
      if (rise_cyc.size() == 1) begin
         chk("wr_e_rise", rise_cyc[0] - a, SETUP);
         chk("wr_db", rise_db[0], data[7:0]);
         chk("wr_rs", rise_rs[0], data[9]);
      end
      if (width_q.size() == 1) chk("wr_e_width", width_q[0], E_HIGH);
      else chk("wr_width_count", width_q.size(), 1);
      if (fin_cyc.size() == 1) chk("wr_finish_lat", fin_cyc[0] - a, lat - 1);
      chk("wr_ready_idle", bus.ready, 1);
      chk("wr_db_retained", bus.lcd_db, data[7:0]);
      chk("wr_rs_retained", bus.lcd_rs, data[9]);
      chk("wr_rw", bus.lcd_rw, 0);
   endtask

   // start held high across two transfers.
   task automatic back_to_back();
      int a1, a2, lat;
      lat = latency(10'h248);
      clear_mon();
      bus.lcd_data = 10'h248;
      bus.start    = 1'b1;
      tick();
      a1 = cyc;
      bus.lcd_data = 10'h249;
      a2 = a1 + lat + 1;
      while (cyc < a2 + lat) begin
         tick();
         if (cyc == a2) bus.start = 1'b0;
      end
      chk("b2b_e_count", rise_cyc.size(), 2);
      chk("b2b_fin_count", fin_cyc.size(), 2);
      if (rise_cyc.size() == 2) begin
         chk("b2b_db0", rise_db[0], 8'h48);
         chk("b2b_db1", rise_db[1], 8'h49);
         chk("b2b_rs1", rise_rs[1], 1);
      end
      if (fin_cyc.size() == 2) begin
         chk("b2b_fin0", fin_cyc[0] - a1, lat - 1);
         chk("b2b_fin_gap", fin_cyc[1] - fin_cyc[0], 20);
      end
   endtask

   // Reset asserted while E is high, then a full re-init.
   task automatic reset_abort();
      int a;
      clear_mon();
      bus.lcd_data = 10'h255;
      bus.start    = 1'b1;
      tick();
      a = cyc;
      bus.start = 1'b0;
      while (cyc < a + SETUP + 1) tick();
      chk("abort_e_before", bus.lcd_e, 1);
      rst = 1'b0;
      #1;
      chk("abort_e", bus.lcd_e, 0);
      chk("abort_ready", bus.ready, 0);
      chk("abort_finish", bus.finish, 0);
      chk("abort_db", bus.lcd_db, 8'h00);
      chk("abort_rs", bus.lcd_rs, 0);
      repeat (3) tick();
      run_init();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] data;
      bus.start    = 1'b0;
      bus.lcd_data = 10'h000;
      rst          = 1'b0;
      repeat (3) tick();
      chk("rst_e", bus.lcd_e, 0);
      chk("rst_rs", bus.lcd_rs, 0);
      chk("rst_rw", bus.lcd_rw, 0);
      chk("rst_db", bus.lcd_db, 8'h00);
      chk("rst_finish", bus.finish, 0);
      chk("rst_ready", bus.ready, 0);

      run_init();
      do_write(10'h241, 1'b0);
      do_write(10'h001, 1'b0);
      do_write(10'h000, 1'b0);
      do_write(10'h002, 1'b0);
      do_write(10'h103, 1'b0);
      do_write(10'h201, 1'b0);
      do_write(10'h2AA, 1'b1);
      back_to_back();
      reset_abort();
      do_write(10'h241, 1'b0);

      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 2) == 0)
            data = {1'b0, 1'($urandom), 6'd0, 2'($urandom)};
         else
            data = 10'($urandom);
         do_write(data, 1'($urandom));
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
